// File: rtl/axi4_lite_pkg.sv
// ----------------------------------------------------------------------------
// axi4_lite_pkg
//   Shared definitions for the AXI4-Lite register slave:
//   - AXI response codes (OKAY / SLVERR)
//   - write channel FSM state type (W_IDLE/W_ADDR/W_DATA/W_RESP)
//   - read channel FSM state type  (R_IDLE/R_DATA)
// ----------------------------------------------------------------------------
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // W_ADDR: address taken, still waiting for data
    // W_DATA: data taken, still waiting for address
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// ----------------------------------------------------------------------------
// axi4_lite_addr_decode
//   Purely combinational byte-address decoder for the register bank.
//   Word index = (addr - BASE_ADDR) >> 2; the two byte-offset bits are ignored.
//   Indices 0..NUM_REGS-1 are RW registers, index NUM_REGS is the RO status word.
// Ports
//   i_addr      in  ADDR_WIDTH  byte address to decode
//   o_idx       out IDX_W       word index (valid when o_in_range)
//   o_in_range  out 1           address maps to a RW register or the status word
//   o_is_ro     out 1           address maps to the read-only status word
// ----------------------------------------------------------------------------
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_2000,
    parameter int                    IDX_W      = $clog2(NUM_REGS + 1)
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_in_range,
    output logic                  o_is_ro
);

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [ADDR_WIDTH-1:0] w_word;

    assign w_offset = i_addr - BASE_ADDR;
    assign w_word   = w_offset >> 2;

    // The full-width word number is compared so that addresses far above the
    // bank do not alias back into it through the truncated index.
    assign o_in_range = (i_addr >= BASE_ADDR) && (w_word <= ADDR_WIDTH'(NUM_REGS));
    assign o_is_ro    = o_in_range && (w_word == ADDR_WIDTH'(NUM_REGS));
    assign o_idx      = w_word[IDX_W-1:0];

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// axi4_lite_reg_slave
//   AXI4-Lite slave register bank: NUM_REGS read/write word registers with
//   byte strobes plus one read-only status word at index NUM_REGS.
//   Write and read channels are independent FSMs and run concurrently.
//
// Build option
//   AXI_SLVERR_EN  when defined, out-of-range / read-only writes answer SLVERR
//                  and out-of-range reads answer SLVERR; otherwise every
//                  response is OKAY.
//
// Ports
//   aclk, aresetn            clock; synchronous active-low reset
//   awvalid/awready/awaddr/awprot   write address channel (awprot ignored)
//   wvalid/wready/wdata/wstrb       write data channel
//   bvalid/bready/bresp             write response channel
//   arvalid/arready/araddr/arprot   read address channel (arprot ignored)
//   rvalid/rready/rdata/rresp       read data channel
//   status_in                        read-only word at index NUM_REGS
//   reg_q                            all RW registers, index 0 in the LSBs
// ----------------------------------------------------------------------------
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_2000
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [1:0]                     bresp,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REGS + 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    wr_state_t r_wr_state;
    wr_state_t w_wr_state_next;
    rd_state_t r_rd_state;
    rd_state_t w_rd_state_next;

    logic                  r_rst_done;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Holding registers for whichever of AW / W arrives first
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_wr_in_range;
    logic                  w_wr_is_ro;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_rd_in_range;
    logic                  w_rd_is_ro;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [1:0]            w_bresp;
    logic [1:0]            w_rresp;
    logic                  w_unused_prot;

    assign w_unused_prot = ^{awprot, arprot};

    assign w_aw_hs = awvalid && r_awready;
    assign w_w_hs  = wvalid  && r_wready;
    assign w_ar_hs = arvalid && r_arready;

    // On the commit edge the late-arriving half comes straight from the bus,
    // the early half from the holding register.
    assign w_wr_addr = w_aw_hs ? awaddr : r_awaddr;
    assign w_wr_data = w_w_hs  ? wdata  : r_wdata;
    assign w_wr_strb = w_w_hs  ? wstrb  : r_wstrb;

    // ------------------------------------------------------------------
    // Address decoders, one per channel
    // ------------------------------------------------------------------
    axi4_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_wr_decode (
        .i_addr     (w_wr_addr),
        .o_idx      (w_wr_idx),
        .o_in_range (w_wr_in_range),
        .o_is_ro    (w_wr_is_ro)
    );

    axi4_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_rd_decode (
        .i_addr     (araddr),
        .o_idx      (w_rd_idx),
        .o_in_range (w_rd_in_range),
        .o_is_ro    (w_rd_is_ro)
    );

`ifdef AXI_SLVERR_EN
    assign w_bresp = (w_wr_in_range && !w_wr_is_ro) ? RESP_OKAY : RESP_SLVERR;
    assign w_rresp = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
    assign w_bresp = RESP_OKAY;
    assign w_rresp = RESP_OKAY;
`endif

    // ------------------------------------------------------------------
    // Reset release tracker: readies stay low on the release edge and
    // rise on the edge after it.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_state_next = r_wr_state;
        w_commit        = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit        = 1'b1;
                    w_wr_state_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_wr_state_next = W_ADDR;
                end else if (w_w_hs) begin
                    w_wr_state_next = W_DATA;
                end
            end
            W_ADDR: begin
                if (w_w_hs) begin
                    w_commit        = 1'b1;
                    w_wr_state_next = W_RESP;
                end
            end
            W_DATA: begin
                if (w_aw_hs) begin
                    w_commit        = 1'b1;
                    w_wr_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_wr_state_next = W_IDLE;
                end
            end
            default: w_wr_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            r_wr_state <= w_wr_state_next;
            // Readies are registered copies of the next state's acceptance
            r_awready  <= r_rst_done &&
                          ((w_wr_state_next == W_IDLE) || (w_wr_state_next == W_DATA));
            r_wready   <= r_rst_done &&
                          ((w_wr_state_next == W_IDLE) || (w_wr_state_next == W_ADDR));
            r_bvalid   <= (w_wr_state_next == W_RESP);
            if (w_aw_hs) begin
                r_awaddr <= awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= wdata;
                r_wstrb <= wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_bresp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register bank: byte-lane writes; RO and out-of-range writes dropped
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && w_wr_in_range && !w_wr_is_ro) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_idx == IDX_W'(i)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_wr_strb[b]) begin
                            r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    // Reads sample r_regs before any same-edge write lands, so a
    // simultaneous write/read to one register returns the old value.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            if (w_rd_is_ro) begin
                w_rd_word = status_in;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_rd_idx == IDX_W'(i)) begin
                        w_rd_word = r_regs[i];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        case (r_rd_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    w_rd_state_next = R_IDLE;
                end
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_state_next;
            r_arready  <= r_rst_done && (w_rd_state_next == R_IDLE);
            r_rvalid   <= (w_rd_state_next == R_DATA);
            if (w_ar_hs) begin
                r_rdata <= w_rd_word;
                r_rresp <= w_rresp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

endmodule
